// File: rtl/axis_pattern_gen.sv
// AXI4-Stream video test-pattern source: emits H_ACTIVE x V_ACTIVE frames of
// 24-bit RGB pixels (colour bars, grey ramp, checkerboard or solid colour).
module axis_pattern_gen #(
  parameter int H_ACTIVE  = 480,
  parameter int V_ACTIVE  = 272,
  parameter int FRAME_GAP = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [1:0]  mode,
  input  logic [23:0] solid_rgb,
  output logic [31:0] axis_tdata,
  output logic        axis_tvalid,
  input  logic        axis_tready,
  output logic        axis_tuser,
  output logic        axis_tlast,
  output logic [3:0]  axis_tstrb,
  output logic [15:0] frame_cnt,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, ACTIVE, GAP} state_e;

  localparam logic [15:0] X_LAST = 16'(H_ACTIVE - 1);
  localparam logic [15:0] Y_LAST = 16'(V_ACTIVE - 1);
  localparam logic [15:0] G_LAST = 16'(FRAME_GAP - 1);
  localparam logic [15:0] BAR_W  = 16'(H_ACTIVE / 8);

  state_e      state_q, state_d;
  logic [15:0] x_q, x_d, y_q, y_d;
  logic [15:0] gap_q, gap_d;
  logic [1:0]  mode_q, mode_d;
  logic [23:0] solid_q, solid_d;
  logic [7:0]  fcb_q, fcb_d;
  logic [15:0] fcnt_q, fcnt_d;
  logic [23:0] rgb_q, rgb_d;
  logic        tvalid_q, tvalid_d;
  logic        tuser_q, tuser_d;
  logic        tlast_q, tlast_d;

  logic        xfer, eol, eof, gap_done, start;
  logic [15:0] nx, ny;

  function automatic logic [23:0] pix(input logic [1:0]  m,
                                      input logic [23:0] s,
                                      input logic [7:0]  fcb,
                                      input logic [15:0] x,
                                      input logic [15:0] y);
    logic [15:0] k;
    logic [7:0]  g;
    logic [23:0] c;
    k = x / BAR_W;
    g = x[7:0] + fcb;
    c = '0;
    case (m)
      2'd0: begin
        if (k > 16'd7) k = 16'd7;
        case (k[2:0])
          3'd0:    c = 24'hFFFFFF;
          3'd1:    c = 24'hFFFF00;
          3'd2:    c = 24'h00FFFF;
          3'd3:    c = 24'h00FF00;
          3'd4:    c = 24'hFF00FF;
          3'd5:    c = 24'hFF0000;
          3'd6:    c = 24'h0000FF;
          default: c = 24'h000000;
        endcase
      end
      2'd1:    c = {g, g, g};
      2'd2:    c = (x[4] ^ y[4]) ? '1 : '0;
      default: c = s;
    endcase
    return c;
  endfunction

  assign xfer     = tvalid_q & axis_tready;
  assign eol      = (x_q == X_LAST);
  assign eof      = eol && (y_q == Y_LAST);
  assign gap_done = (gap_q == G_LAST);
  assign start    = enable && ((state_q == IDLE) || ((state_q == GAP) && gap_done));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (enable) state_d = ACTIVE;
      ACTIVE:  if (xfer && eof) state_d = GAP;
      GAP:     if (gap_done) state_d = enable ? ACTIVE : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The pixel after the one being transferred is computed here so tdata, tuser
  // and tlast are all registered together and change only on a transfer.
  always_comb begin
    x_d      = x_q;
    y_d      = y_q;
    gap_d    = gap_q;
    mode_d   = mode_q;
    solid_d  = solid_q;
    fcb_d    = fcb_q;
    fcnt_d   = fcnt_q;
    rgb_d    = rgb_q;
    tvalid_d = tvalid_q;
    tuser_d  = tuser_q;
    tlast_d  = tlast_q;
    nx       = '0;
    ny       = '0;
    case (state_q)
      ACTIVE: begin
        if (xfer) begin
          if (eof) begin
            tvalid_d = 1'b0;
            tuser_d  = 1'b0;
            tlast_d  = 1'b0;
            fcnt_d   = fcnt_q + 16'd1;
            gap_d    = '0;
          end else begin
            nx      = eol ? '0 : x_q + 16'd1;
            ny      = eol ? y_q + 16'd1 : y_q;
            x_d     = nx;
            y_d     = ny;
            rgb_d   = pix(mode_q, solid_q, fcb_q, nx, ny);
            tuser_d = 1'b0;
            tlast_d = (nx == X_LAST);
          end
        end
      end
      GAP:     gap_d = gap_q + 16'd1;
      default: ;
    endcase
    if (start) begin
      mode_d   = mode;
      solid_d  = solid_rgb;
      fcb_d    = fcnt_q[7:0];
      x_d      = '0;
      y_d      = '0;
      rgb_d    = pix(mode, solid_rgb, fcnt_q[7:0], '0, '0);
      tvalid_d = 1'b1;
      tuser_d  = 1'b1;
      tlast_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q      <= '0;
      y_q      <= '0;
      gap_q    <= '0;
      mode_q   <= '0;
      solid_q  <= '0;
      fcb_q    <= '0;
      fcnt_q   <= '0;
      rgb_q    <= '0;
      tvalid_q <= 1'b0;
      tuser_q  <= 1'b0;
      tlast_q  <= 1'b0;
    end else begin
      x_q      <= x_d;
      y_q      <= y_d;
      gap_q    <= gap_d;
      mode_q   <= mode_d;
      solid_q  <= solid_d;
      fcb_q    <= fcb_d;
      fcnt_q   <= fcnt_d;
      rgb_q    <= rgb_d;
      tvalid_q <= tvalid_d;
      tuser_q  <= tuser_d;
      tlast_q  <= tlast_d;
    end
  end

  assign axis_tdata  = {8'h00, rgb_q};
  assign axis_tvalid = tvalid_q;
  assign axis_tuser  = tuser_q;
  assign axis_tlast  = tlast_q;
  assign axis_tstrb  = 4'hF;
  assign frame_cnt   = fcnt_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_axis_pattern_gen.sv
// Testbench for axis_pattern_gen with small frames (8x4, gap 2): table vectors,
// directed corner sequences and random-tready frames against a pixel model.
module tb_axis_pattern_gen;

  localparam int H = 8;
  localparam int V = 4;
  localparam int G = 2;
  localparam int N = H * V;

  typedef struct packed {
    logic [31:0] d;
    logic        u;
    logic        l;
  } beat_t;

  typedef struct {
    int          idx;
    logic [31:0] d;
    logic        u;
    logic        l;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [1:0]  mode;
  logic [23:0] solid;
  logic [31:0] tdata;
  logic        tvalid;
  logic        tready;
  logic        tuser;
  logic        tlast;
  logic [3:0]  tstrb;
  logic [15:0] frame_cnt;
  logic        busy;

  int          checks   = 0;
  int          failures = 0;
  beat_t       bq[$];
  vec_t        tbl[$];
  bit          stall_pending = 1'b0;
  beat_t       stall_beat;
  logic [15:0] exp_fc;

  always #5 clk = ~clk;

  axis_pattern_gen #(.H_ACTIVE(H), .V_ACTIVE(V), .FRAME_GAP(G)) dut (
    .clk(clk), .rst(rst), .enable(enable), .mode(mode), .solid_rgb(solid),
    .axis_tdata(tdata), .axis_tvalid(tvalid), .axis_tready(tready),
    .axis_tuser(tuser), .axis_tlast(tlast), .axis_tstrb(tstrb),
    .frame_cnt(frame_cnt), .busy(busy)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected beat straight from the pattern rules, by linear beat index.
  function automatic beat_t model(input logic [1:0] m, input logic [23:0] s,
                                  input logic [7:0] fc, input int idx);
    int          x, y, k, g;
    logic [23:0] rgb;
    beat_t       b;
    x = idx % H;
    y = (idx / H) % V;
    case (m)
      2'd0: begin
        k = x / (H / 8);
        if (k > 7) k = 7;
        case (k)
          0:       rgb = 24'hFFFFFF;
          1:       rgb = 24'hFFFF00;
          2:       rgb = 24'h00FFFF;
          3:       rgb = 24'h00FF00;
          4:       rgb = 24'hFF00FF;
          5:       rgb = 24'hFF0000;
          6:       rgb = 24'h0000FF;
          default: rgb = 24'h000000;
        endcase
      end
      2'd1: begin
        g   = (x + int'(fc)) % 256;
        rgb = {g[7:0], g[7:0], g[7:0]};
      end
      2'd2:    rgb = ((((x / 16) % 2) ^ ((y / 16) % 2)) != 0) ? 24'hFFFFFF : 24'h000000;
      default: rgb = s;
    endcase
    b.d = {8'h00, rgb};
    b.u = (x == 0) && (y == 0);
    b.l = (x == H - 1);
    return b;
  endfunction

  task automatic step(input bit rdy);
    beat_t cur;
    @(negedge clk);
    tready = rdy;
    #1;
    cur.d = tdata;
    cur.u = tuser;
    cur.l = tlast;
    if (stall_pending) chk("stall_hold", {tvalid, cur}, {1'b1, stall_beat});
    if (tvalid && tready) bq.push_back(cur);
    stall_pending = tvalid && !tready;
    stall_beat    = cur;
  endtask

  task automatic wait_beats(input int target, input bit rnd);
    int budget = 4000;
    while (bq.size() < target && budget > 0) begin
      step(rnd ? 1'($urandom_range(0, 1)) : 1'b1);
      budget--;
    end
    chk("beat_count", 64'(bq.size()), 64'(target));
  endtask

  task automatic check_frame(input int base, input logic [1:0] m, input logic [23:0] s,
                             input logic [7:0] fc, input string tag);
    for (int i = 0; i < N; i++)
      chk($sformatf("%s_beat%0d", tag, i), 64'(bq[base + i]), 64'(model(m, s, fc, i)));
  endtask

  task automatic check_table(input string tag);
    for (int i = 0; i < tbl.size(); i++)
      chk($sformatf("tbl_%s_%0d", tag, tbl[i].idx), 64'(bq[tbl[i].idx]),
          64'({tbl[i].d, tbl[i].u, tbl[i].l}));
  endtask

  task automatic settle_idle(input string tag);
    repeat (6) step(1'b1);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_tvalid"}, 64'(tvalid), 64'd0);
    chk({tag, "_frame_cnt"}, 64'(frame_cnt), 64'(exp_fc));
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_tvalid"}, 64'(tvalid), 64'd0);
    chk({tag, "_tdata"}, 64'(tdata), 64'd0);
    chk({tag, "_tuser"}, 64'(tuser), 64'd0);
    chk({tag, "_tlast"}, 64'(tlast), 64'd0);
    chk({tag, "_tstrb"}, 64'(tstrb), 64'hF);
    chk({tag, "_frame_cnt"}, 64'(frame_cnt), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
  endtask

  initial begin
    int lows;
    logic [1:0]  rm;
    logic [23:0] rs;

    tbl.push_back('{0,  32'h00FFFFFF, 1'b1, 1'b0});
    tbl.push_back('{1,  32'h00FFFF00, 1'b0, 1'b0});
    tbl.push_back('{2,  32'h0000FFFF, 1'b0, 1'b0});
    tbl.push_back('{3,  32'h0000FF00, 1'b0, 1'b0});
    tbl.push_back('{4,  32'h00FF00FF, 1'b0, 1'b0});
    tbl.push_back('{5,  32'h00FF0000, 1'b0, 1'b0});
    tbl.push_back('{6,  32'h000000FF, 1'b0, 1'b0});
    tbl.push_back('{7,  32'h00000000, 1'b0, 1'b1});
    tbl.push_back('{8,  32'h00FFFFFF, 1'b0, 1'b0});
    tbl.push_back('{15, 32'h00000000, 1'b0, 1'b1});
    tbl.push_back('{23, 32'h00000000, 1'b0, 1'b1});
    tbl.push_back('{24, 32'h00FFFFFF, 1'b0, 1'b0});
    tbl.push_back('{31, 32'h00000000, 1'b0, 1'b1});

    rst = 1'b1; enable = 1'b0; mode = 2'd0; solid = '0; tready = 1'b1; exp_fc = '0;
    repeat (3) @(negedge clk);
    #1;
    check_reset_values("reset");
    rst = 1'b0;

    // Colour bars, single enable pulse, tready=1
    bq.delete();
    mode = 2'd0; enable = 1'b1;
    step(1'b1);
    enable = 1'b0;
    chk("first_tvalid", 64'(tvalid), 64'd1);
    chk("first_tuser", 64'(tuser), 64'd1);
    wait_beats(N, 1'b0);
    check_table("bars");
    check_frame(0, 2'd0, 24'h0, exp_fc[7:0], "bars");
    exp_fc++;
    settle_idle("bars_end");

    // Ramp with enable held: gap length and second-frame ramp offset
    @(negedge clk); #2; rst = 1'b1; #1; rst = 1'b0;
    exp_fc = '0; stall_pending = 1'b0;
    bq.delete();
    mode = 2'd1; enable = 1'b1;
    wait_beats(N, 1'b0);
    lows = 0;
    for (int i = 0; i < 50; i++) begin
      step(1'b1);
      if (tvalid) break;
      lows++;
    end
    chk("gap_cycles", 64'(lows), 64'(G));
    chk("ramp_f2_first", 64'(bq[N].d), 64'h00010101);
    enable = 1'b0;
    wait_beats(2 * N, 1'b0);
    check_frame(0, 2'd1, 24'h0, 8'd0, "ramp_f1");
    check_frame(N, 2'd1, 24'h0, 8'd1, "ramp_f2");
    exp_fc = 16'd2;
    settle_idle("ramp_end");

    // Colour bars under random back-pressure
    bq.delete();
    mode = 2'd0; enable = 1'b1;
    step(1'($urandom_range(0, 1)));
    enable = 1'b0;
    wait_beats(N, 1'b1);
    check_table("bars_stall");
    check_frame(0, 2'd0, 24'h0, exp_fc[7:0], "bars_stall");
    exp_fc++;
    settle_idle("bars_stall_end");

    // Solid colour changed mid-frame; enable dropped mid second frame
    bq.delete();
    mode = 2'd3; solid = 24'h123456; enable = 1'b1;
    wait_beats(10, 1'b1);
    solid = 24'hABCDEF;
    wait_beats(N + 8, 1'b1);
    enable = 1'b0;
    wait_beats(2 * N, 1'b1);
    check_frame(0, 2'd3, 24'h123456, 8'd0, "solid_f1");
    check_frame(N, 2'd3, 24'hABCDEF, 8'd0, "solid_f2");
    exp_fc += 16'd2;
    settle_idle("solid_end");

    // Asynchronous reset in line 2
    bq.delete();
    mode = 2'd0; enable = 1'b1;
    wait_beats(2 * H + 3, 1'b1);
    #2; rst = 1'b1; #1;
    check_reset_values("midrst");
    exp_fc = '0; stall_pending = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    bq.delete();
    wait_beats(1, 1'b0);
    chk("midrst_first_tuser", 64'(bq[0].u), 64'd1);
    chk("midrst_first_beat", 64'(bq[0]), 64'(model(2'd0, 24'h0, 8'd0, 0)));
    enable = 1'b0;
    wait_beats(N, 1'b0);
    check_frame(0, 2'd0, 24'h0, 8'd0, "midrst");
    exp_fc++;
    settle_idle("midrst_end");

    // frame_cnt wrap
    @(negedge clk);
    force dut.fcnt_q = 16'hFFFF;
    @(negedge clk);
    release dut.fcnt_q;
    #1;
    chk("wrap_preload", 64'(frame_cnt), 64'hFFFF);
    exp_fc = 16'hFFFF;
    bq.delete();
    mode = 2'd1; enable = 1'b1;
    step(1'b1);
    enable = 1'b0;
    wait_beats(N, 1'b1);
    check_frame(0, 2'd1, 24'h0, 8'hFF, "wrap");
    exp_fc++;
    settle_idle("wrap_end");
    chk("wrap_zero", 64'(frame_cnt), 64'h0000);

    // Random frames: random mode, colour and back-pressure
    for (int f = 0; f < 6; f++) begin
      rm = 2'($urandom_range(0, 3));
      rs = 24'($urandom);
      bq.delete();
      mode = rm; solid = rs; enable = 1'b1;
      step(1'($urandom_range(0, 1)));
      enable = 1'b0;
      mode = 2'($urandom_range(0, 3));
      solid = 24'($urandom);
      wait_beats(N, 1'b1);
      check_frame(0, rm, rs, exp_fc[7:0], $sformatf("rand%0d", f));
      exp_fc++;
      settle_idle($sformatf("rand%0d_end", f));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
